// File: rtl/mcycle_if.sv
// Decoder <-> mcycle_unit request/result bundle.
// Master drives the request, slave returns results.
interface mcycle_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             MCycleOp;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [WIDTH-1:0] Result1;
  logic [WIDTH-1:0] Result2;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, MCycleOp,
    output Operand1, Operand2,
    input  Result1, Result2,
    input  Busy, Done
  );

  modport slave (
    input  Start, MCycleOp,
    input  Operand1, Operand2,
    output Result1, Result2,
    output Busy, Done
  );
endinterface

// File: rtl/mcycle_unit.sv
// Iterative unsigned multiply / restoring divide,
// one bit per cycle, WIDTH+1 cycles to Done.
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input logic     CLK,
  input logic     RESET,
  mcycle_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             op_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] res1;
  logic [WIDTH-1:0] res2;
  logic             done_q;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   madd;
  logic [WIDTH+1:0] sh;
  logic [WIDTH+1:0] diff;
  logic             ge;
  logic [WIDTH:0]   rem_n;
  logic [WIDTH-1:0] lo_n;

  // rem[WIDTH] stays 0 in both modes, so diff MSB is a true sign
  always_comb begin
    sum   = {1'b0, rem[WIDTH-1:0]} + {1'b0, b_q};
    madd  = lo[0] ? sum : {1'b0, rem[WIDTH-1:0]};
    sh    = {rem, lo[WIDTH-1]};
    diff  = sh - {2'b00, b_q};
    ge    = ~diff[WIDTH+1];
    rem_n = '0;
    lo_n  = '0;
    unique case (1'b1)
      op_q: begin
        rem_n = ge ? diff[WIDTH:0] : sh[WIDTH:0];
        lo_n  = {lo[WIDTH-2:0], ge};
      end
      default: begin
        rem_n = {1'b0, madd[WIDTH:1]};
        lo_n  = {madd[0], lo[WIDTH-1:1]};
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= 1'b0;
      b_q    <= '0;
      rem    <= '0;
      lo     <= '0;
      res1   <= '0;
      res2   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.Start) begin
            state <= COMPUTE;
            cnt   <= '0;
            op_q  <= bus.MCycleOp;
            rem   <= '0;
            b_q   <= bus.MCycleOp ? bus.Operand2
                                  : bus.Operand1;
            lo    <= bus.MCycleOp ? bus.Operand1
                                  : bus.Operand2;
          end
        end
        COMPUTE: begin
          rem <= rem_n;
          lo  <= lo_n;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= DONE;
            done_q <= 1'b1;
            res1   <= lo_n;
            res2   <= rem_n[WIDTH-1:0];
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.Busy = ((state == IDLE) & bus.Start)
                  | (state == COMPUTE);
  assign bus.Done    = done_q;
  assign bus.Result1 = res1;
  assign bus.Result2 = res2;

endmodule

// File: tb/tb_mcycle_unit.sv
// Directed vector bench for mcycle_unit (WIDTH=32).
// Cycle 0 is the cycle a request is first driven.
module tb_mcycle_unit;

  localparam int W = 32;

  logic CLK = 1'b0;
  logic RESET;

  mcycle_if #(.WIDTH(W)) bus ();

  mcycle_unit #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      name;
    logic       op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r1;
    logic [W-1:0] r2;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Issue one op; optionally flush Start or mutate
  // operands at cycle 5 of COMPUTE.
  task automatic run_op(input string tag,
                        input logic op,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic [W-1:0] r1,
                        input logic [W-1:0] r2,
                        input bit mutate,
                        input bit flush);
    bit busy_ok;
    int done_cyc;
    int ndone;
    logic [W-1:0] c1;
    logic [W-1:0] c2;
    busy_ok = 1'b1;
    done_cyc = -1;
    ndone = 0;
    c1 = 'x;
    c2 = 'x;
    @(posedge CLK);
    #1;
    bus.Start = 1'b1;
    bus.MCycleOp = op;
    bus.Operand1 = a;
    bus.Operand2 = b;
    for (int c = 0; c <= 40; c++) begin
      @(negedge CLK);
      if (bus.Busy !== (c <= 32)) busy_ok = 1'b0;
      if (bus.Done === 1'b1) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (c == 33) begin
        c1 = bus.Result1;
        c2 = bus.Result2;
        bus.Start = 1'b0;
      end
      if (c == 5 && mutate) begin
        bus.MCycleOp = ~op;
        bus.Operand1 = 32'h0000_0009;
        bus.Operand2 = 32'h0000_0009;
      end
      if (c == 5 && flush) bus.Start = 1'b0;
    end
    check({tag, "_busy"}, 64'(busy_ok), 64'd1);
    check({tag, "_done_cyc"}, 64'(done_cyc), 64'd33);
    check({tag, "_done_cnt"}, 64'(ndone), 64'd1);
    check({tag, "_r1"}, 64'(c1), 64'(r1));
    check({tag, "_r2"}, 64'(c2), 64'(r2));
  endtask

  initial begin
    int d0;
    int d1;
    int nd;
    bit consec;
    bit prev;
    logic [W-1:0] s1[2];
    logic [W-1:0] s2[2];

    vecs.push_back('{"mul7x6", 1'b0, 32'd7, 32'd6,
                     32'd42, 32'd0});
    vecs.push_back('{"mulmax", 1'b0, 32'hFFFF_FFFF,
                     32'hFFFF_FFFF, 32'h0000_0001,
                     32'hFFFF_FFFE});
    vecs.push_back('{"mul0", 1'b0, 32'd0, 32'd12345,
                     32'd0, 32'd0});
    vecs.push_back('{"mul2p16", 1'b0, 32'h0001_0000,
                     32'h0001_0000, 32'd0, 32'd1});
    vecs.push_back('{"div100_7", 1'b1, 32'd100, 32'd7,
                     32'd14, 32'd2});
    vecs.push_back('{"div_msb", 1'b1, 32'h8000_0000,
                     32'hFFFF_FFFF, 32'd0,
                     32'h8000_0000});
    vecs.push_back('{"div_by0", 1'b1, 32'd5, 32'd0,
                     32'hFFFF_FFFF, 32'd5});
    vecs.push_back('{"div_small", 1'b1, 32'd3, 32'd5,
                     32'd0, 32'd3});
    vecs.push_back('{"div_hex", 1'b1, 32'hDEAD_BEEF,
                     32'h10, 32'h0DEA_DBEE, 32'hF});
    vecs.push_back('{"div_by1", 1'b1, 32'hFFFF_FFFF,
                     32'd1, 32'hFFFF_FFFF, 32'd0});

    RESET = 1'b1;
    bus.Start = 1'b1;
    bus.MCycleOp = 1'b0;
    bus.Operand1 = '0;
    bus.Operand2 = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_busy_start1", 64'(bus.Busy), 64'd1);
    bus.Start = 1'b0;
    #1;
    check("rst_busy_start0", 64'(bus.Busy), 64'd0);
    check("rst_done", 64'(bus.Done), 64'd0);
    check("rst_r1", 64'(bus.Result1), 64'd0);
    check("rst_r2", 64'(bus.Result2), 64'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a,
             vecs[i].b, vecs[i].r1, vecs[i].r2,
             1'b0, 1'b0);

    // flushed instruction still completes
    run_op("flush", 1'b0, 32'd5, 32'd5, 32'd25,
           32'd0, 1'b0, 1'b1);

    // back-to-back with Start held high
    @(posedge CLK);
    #1;
    bus.Start = 1'b1;
    bus.MCycleOp = 1'b0;
    bus.Operand1 = 32'd3;
    bus.Operand2 = 32'd4;
    d0 = -1;
    d1 = -1;
    nd = 0;
    consec = 1'b0;
    prev = 1'b0;
    s1[0] = 'x; s1[1] = 'x;
    s2[0] = 'x; s2[1] = 'x;
    for (int c = 0; c <= 75; c++) begin
      @(negedge CLK);
      if (bus.Done === 1'b1) begin
        if (prev) consec = 1'b1;
        if (nd < 2) begin
          s1[nd] = bus.Result1;
          s2[nd] = bus.Result2;
        end
        if (nd == 0) d0 = c;
        if (nd == 1) d1 = c;
        nd++;
      end
      prev = (bus.Done === 1'b1);
      if (c == 33) begin
        bus.MCycleOp = 1'b1;
        bus.Operand1 = 32'd9;
        bus.Operand2 = 32'd2;
      end
      if (c == 67) bus.Start = 1'b0;
    end
    check("b2b_done0_cyc", 64'(d0), 64'd33);
    check("b2b_done1_cyc", 64'(d1), 64'd67);
    check("b2b_done_cnt", 64'(nd), 64'd2);
    check("b2b_no_consec", 64'(consec), 64'd0);
    check("b2b_mul_r1", 64'(s1[0]), 64'd12);
    check("b2b_mul_r2", 64'(s2[0]), 64'd0);
    check("b2b_div_r1", 64'(s1[1]), 64'd4);
    check("b2b_div_r2", 64'(s2[1]), 64'd1);

    // reset at cycle 10 of a multiply
    @(posedge CLK);
    #1;
    bus.Start = 1'b1;
    bus.MCycleOp = 1'b0;
    bus.Operand1 = 32'd11;
    bus.Operand2 = 32'd13;
    for (int c = 0; c < 10; c++) @(negedge CLK);
    check("mid_busy", 64'(bus.Busy), 64'd1);
    RESET = 1'b1;
    bus.Start = 1'b0;
    @(negedge CLK);
    check("mrst_idle", 64'(bus.Busy), 64'd0);
    check("mrst_done", 64'(bus.Done), 64'd0);
    check("mrst_r1", 64'(bus.Result1), 64'd0);
    check("mrst_r2", 64'(bus.Result2), 64'd0);
    RESET = 1'b0;
    @(negedge CLK);
    check("post_rst_done", 64'(bus.Done), 64'd0);

    run_op("reissue", 1'b0, 32'd2, 32'd2, 32'd4,
           32'd0, 1'b1, 1'b0);
    run_op("mutdiv", 1'b1, 32'd100, 32'd7, 32'd14,
           32'd2, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mcycle_unit.md
# mcycle_unit

Multi-cycle unsigned multiply/divide unit that sits directly downstream of the instruction decoder. It consumes the decoder's start request and operation select, and computes iteratively at one bit per cycle. It returns a one-cycle `Done` pulse, which the decoder turns into its register write enable. While `Busy` is high, the pipeline holds the instruction (and thus `Start`) stable.

## Interface
- `WIDTH`, default 32: operand width in bits.

- `CLK`  in  1  clock; all state updates on its rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `Start`  in  1  request; level-held by the decoder for the whole instruction.
- `MCycleOp`  in  1  operation select: 0 = unsigned multiply, 1 = unsigned divide.
- `Operand1`  in  WIDTH  multiplicand or dividend.
- `Operand2`  in  WIDTH  multiplier or divisor.
- `Result1`  out  WIDTH  product low half, or quotient.
- `Result2`  out  WIDTH  product high half, or remainder.
- `Busy`  out  1  stall request to the pipeline.
- `Done`  out  1  one-cycle pulse; results valid this cycle.

## Operation
- FSM states and transitions:
  - IDLE
    - `Start`=1: latch `Operand1`, `Operand2` and `MCycleOp`; clear the iteration counter; go to COMPUTE.
    - `Start`=0: stay in IDLE.
  - COMPUTE
    - Perform one iteration per cycle.
    - After the iteration with counter = WIDTH-1, go to DONE.
  - DONE
    - Go to IDLE unconditionally.
    - `Start` is ignored in this cycle, because it still belongs to the completing instruction.
- Outputs:
  - `Busy` = (IDLE & `Start`) | COMPUTE. It is combinational, so the stall begins in the same cycle the request appears.
  - `Done` = (state == DONE). It is registered state, not gated by `Start`.
- Inputs are sampled only on the IDLE→COMPUTE edge. Changes to the operand inputs during COMPUTE have no effect.
- Multiply (shift-add), using a 2·WIDTH accumulator:
  - Each cycle: if multiplier LSB = 1, add the multiplicand to the upper half.
  - Then shift the {carry, accumulator} pair right by 1, and shift the multiplier right by 1.
  - The carry out of the WIDTH-bit add is retained, so there is no overflow loss.
  - Final result: `Result2`:`Result1` = full 2·WIDTH product.
- Divide (restoring), using a WIDTH+1-bit partial remainder:
  - Each cycle: shift the next dividend MSB into the remainder, then trial-subtract the divisor.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - `Result1` = quotient, `Result2` = remainder.
- Divide by zero is not trapped. The natural restoring result is required: quotient = all ones, remainder = dividend.
- `Result1`/`Result2` are registered. They update only on entry to DONE and hold their values until the next DONE.
- Reset (any state, including mid-COMPUTE):
  - state → IDLE; counter → 0; `Result1` = `Result2` = 0; `Done` = 0.
  - `Busy` = `Start` (combinational).
  - Any partial computation is discarded.

## Timing
- The request is accepted at cycle 0 (IDLE with `Start`=1).
- COMPUTE occupies cycles 1..WIDTH.
- `Done`=1 in cycle WIDTH+1, with results valid in that cycle.
- Total latency is WIDTH+1 cycles from acceptance to `Done`. With the default WIDTH = 32, `Done` asserts in cycle 33.
- `Busy` is high for cycles 0..WIDTH and low in the DONE cycle. The pipeline therefore advances on the DONE edge, and the register file write (`MWrite` = `Done`) occurs in that same cycle.
- Back-to-back requests: after DONE, the unit returns to IDLE. If the following instruction holds `Start`=1, it is accepted in cycle WIDTH+2, which gives one bubble between operations.
- `Start` deasserting mid-COMPUTE (a flushed instruction) does not abort the operation. The unit completes and pulses `Done`; the decoder discards the pulse because its `MWrite` is no longer qualified.

## Test plan
- Multiply 7 × 6 (WIDTH = 32): `Busy` high for 33 cycles, then `Done` pulses once at cycle 33 with `Result1`=42, `Result2`=0.
- Multiply 0xFFFFFFFF × 0xFFFFFFFF: `Result1`=0x00000001, `Result2`=0xFFFFFFFE.
- Divide 100 / 7: `Result1`=14, `Result2`=2. Divide 0x80000000 / 0xFFFFFFFF: quotient 0, remainder 0x80000000.
- Divide 5 / 0: `Result1`=0xFFFFFFFF, `Result2`=5, `Done` at cycle 33 (no hang).
- Back-to-back with `Start` held high: multiply 3 × 4, then divide 9 / 2. Expect `Done` at cycles 33 and 67, results 12/0 then 4/1, and `Done` never asserting on two consecutive cycles.
- `RESET` asserted at cycle 10 of a multiply:
  - Next cycle: IDLE, results 0, `Done` 0.
  - Re-issuing 2 × 2 yields `Result1`=4 after 33 cycles.
  - Changing operands mid-COMPUTE does not alter the result.
